// File: rtl/fwd_operand_pipe_if.sv
// Bus between the forwarding control / pipeline side and the EX operand
// delivery block. Control unit side uses master, operand pipe uses slave.
interface fwd_operand_pipe_if #(
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          ADVANCE;
  logic [DW-1:0] RESULT_IN;
  logic [4:0]    DEST_IN;
  logic          DEST_VALID_IN;
  logic [1:0]    forwardA;
  logic [1:0]    forwardB;
  logic [DW-1:0] RS_DATA;
  logic [DW-1:0] RT_DATA;
  logic [DW-1:0] OPERAND_A;
  logic [DW-1:0] OPERAND_B;
  logic          SEL_ERR;
  logic [CW-1:0] FWD_CNT_NEW;
  logic [CW-1:0] FWD_CNT_OLD;

  modport master (
    output ADVANCE, RESULT_IN, DEST_IN, DEST_VALID_IN,
    output forwardA, forwardB, RS_DATA, RT_DATA,
    input  OPERAND_A, OPERAND_B, SEL_ERR, FWD_CNT_NEW, FWD_CNT_OLD
  );

  modport slave (
    input  ADVANCE, RESULT_IN, DEST_IN, DEST_VALID_IN,
    input  forwardA, forwardB, RS_DATA, RT_DATA,
    output OPERAND_A, OPERAND_B, SEL_ERR, FWD_CNT_NEW, FWD_CNT_OLD
  );
endinterface

// File: rtl/fwd_operand_pipe.sv
// EX-stage operand delivery: two-slot result history (older/newer), select
// mux with $zero suppression, sticky select-error flag and saturating
// forward-event counters.
module fwd_operand_pipe #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic              CLOCK,
  input logic              RESET,
  fwd_operand_pipe_if.slave bus
);

  // Saturating add of a 0..2 increment; sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [1:0]    inc);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, inc};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  logic [DW-1:0] old_data_q, old_data_d, new_data_q, new_data_d;
  logic [4:0]    old_dest_q, old_dest_d, new_dest_q, new_dest_d;
  logic          old_vld_q,  old_vld_d,  new_vld_q,  new_vld_d;
  logic          sel_err_q,  sel_err_d;
  logic [CW-1:0] cnt_new_q,  cnt_new_d,  cnt_old_q,  cnt_old_d;

  logic          new_hit, old_hit;
  logic          a_new, a_old, b_new, b_old;
  logic          err_now;
  logic [1:0]    inc_new, inc_old;

  // Operand select: a slot only forwards when it is valid and not $zero.
  always_comb begin
    new_hit = new_vld_q && (new_dest_q != 5'd0);
    old_hit = old_vld_q && (old_dest_q != 5'd0);
    a_new   = (bus.forwardA == 2'b10) && new_hit;
    a_old   = (bus.forwardA == 2'b01) && old_hit;
    b_new   = (bus.forwardB == 2'b10) && new_hit;
    b_old   = (bus.forwardB == 2'b01) && old_hit;

    bus.OPERAND_A = bus.RS_DATA;
    if (a_new)      bus.OPERAND_A = new_data_q;
    else if (a_old) bus.OPERAND_A = old_data_q;

    bus.OPERAND_B = bus.RT_DATA;
    if (b_new)      bus.OPERAND_B = new_data_q;
    else if (b_old) bus.OPERAND_B = old_data_q;

    // Illegal encoding, or a forward request pointing at an empty slot.
    err_now = (bus.forwardA == 2'b11) || (bus.forwardB == 2'b11) ||
              ((bus.forwardA == 2'b10) && !new_vld_q) ||
              ((bus.forwardA == 2'b01) && !old_vld_q) ||
              ((bus.forwardB == 2'b10) && !new_vld_q) ||
              ((bus.forwardB == 2'b01) && !old_vld_q);

    inc_new = {1'b0, a_new} + {1'b0, b_new};
    inc_old = {1'b0, a_old} + {1'b0, b_old};
  end

  // Next state: history shifts and counters update only on ADVANCE.
  always_comb begin
    old_data_d = old_data_q;
    old_dest_d = old_dest_q;
    old_vld_d  = old_vld_q;
    new_data_d = new_data_q;
    new_dest_d = new_dest_q;
    new_vld_d  = new_vld_q;
    cnt_new_d  = cnt_new_q;
    cnt_old_d  = cnt_old_q;
    sel_err_d  = sel_err_q | err_now;
    if (bus.ADVANCE) begin
      old_data_d = new_data_q;
      old_dest_d = new_dest_q;
      old_vld_d  = new_vld_q;
      new_data_d = bus.RESULT_IN;
      new_dest_d = bus.DEST_IN;
      new_vld_d  = bus.DEST_VALID_IN;
      cnt_new_d  = sat_add(cnt_new_q, inc_new);
      cnt_old_d  = sat_add(cnt_old_q, inc_old);
    end
  end

  // State registers; reset discards history and clears debug state.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      old_data_q <= '0;
      old_dest_q <= '0;
      old_vld_q  <= 1'b0;
      new_data_q <= '0;
      new_dest_q <= '0;
      new_vld_q  <= 1'b0;
      sel_err_q  <= 1'b0;
      cnt_new_q  <= '0;
      cnt_old_q  <= '0;
    end else begin
      old_data_q <= old_data_d;
      old_dest_q <= old_dest_d;
      old_vld_q  <= old_vld_d;
      new_data_q <= new_data_d;
      new_dest_q <= new_dest_d;
      new_vld_q  <= new_vld_d;
      sel_err_q  <= sel_err_d;
      cnt_new_q  <= cnt_new_d;
      cnt_old_q  <= cnt_old_d;
    end
  end

  assign bus.SEL_ERR     = sel_err_q;
  assign bus.FWD_CNT_NEW = cnt_new_q;
  assign bus.FWD_CNT_OLD = cnt_old_q;

endmodule
